// File: rtl/iob_fifo_sync_asym_pkg.sv
// Shared width helpers for the asymmetric synchronous FIFO.
// Ratio math between the write and read word widths.
package iob_fifo_sync_asym_pkg;

    function automatic int iob_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int iob_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int iob_ratio(input int a, input int b);
        return iob_max(a, b) / iob_min(a, b);
    endfunction

endpackage

// File: rtl/iob_fifo_sync_asym_ram.sv
// Asymmetric 2-port RAM adaptor onto N external MINDATA_W-wide banks.
// Narrow side selects one bank by the low address bits; wide side spans all.
module iob_ram_2p_asym
    import iob_fifo_sync_asym_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int N = iob_ratio(W_DATA_W, R_DATA_W),
    localparam int MINDATA_W = iob_min(W_DATA_W, R_DATA_W),
    localparam int MINADDR_W = ADDR_W - $clog2(N),
    localparam int W_ADDR_W = (W_DATA_W >= R_DATA_W) ? MINADDR_W : ADDR_W,
    localparam int R_ADDR_W = (R_DATA_W >= W_DATA_W) ? MINADDR_W : ADDR_W
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      w_en,
    input  logic [W_ADDR_W-1:0]       w_addr,
    input  logic [W_DATA_W-1:0]       w_data,
    input  logic                      r_en,
    input  logic [R_ADDR_W-1:0]       r_addr,
    output logic [R_DATA_W-1:0]       r_data,
    output logic [N-1:0]              ext_mem_w_en,
    output logic [N*MINADDR_W-1:0]    ext_mem_w_addr,
    output logic [N*MINDATA_W-1:0]    ext_mem_w_data,
    output logic                      ext_mem_r_en,
    output logic [N*MINADDR_W-1:0]    ext_mem_r_addr,
    input  logic [N*MINDATA_W-1:0]    ext_mem_r_data
);

    localparam int L = $clog2(N);

    if (W_DATA_W >= R_DATA_W) begin : g_w_wide
        for (genvar i = 0; i < N; i++) begin : g_bank
            assign ext_mem_w_en[i] = w_en;
            assign ext_mem_w_addr[i*MINADDR_W +: MINADDR_W] = MINADDR_W'(w_addr);
            assign ext_mem_w_data[i*MINDATA_W +: MINDATA_W] =
                w_data[i*MINDATA_W +: MINDATA_W];
        end
    end else begin : g_w_narrow
        logic [L-1:0] w_sel;
        assign w_sel = w_addr[L-1:0];
        for (genvar i = 0; i < N; i++) begin : g_bank
            assign ext_mem_w_en[i] = w_en && (w_sel == L'(i));
            assign ext_mem_w_addr[i*MINADDR_W +: MINADDR_W] = w_addr[W_ADDR_W-1:L];
            assign ext_mem_w_data[i*MINDATA_W +: MINDATA_W] = MINDATA_W'(w_data);
        end
    end

    assign ext_mem_r_en = r_en;

    if (R_DATA_W >= W_DATA_W) begin : g_r_wide
        for (genvar i = 0; i < N; i++) begin : g_bank
            assign ext_mem_r_addr[i*MINADDR_W +: MINADDR_W] = MINADDR_W'(r_addr);
        end
        assign r_data = R_DATA_W'(ext_mem_r_data);
    end else begin : g_r_narrow
        logic [L-1:0] sel_q;
        for (genvar i = 0; i < N; i++) begin : g_bank
            assign ext_mem_r_addr[i*MINADDR_W +: MINADDR_W] = r_addr[R_ADDR_W-1:L];
        end
        // bank select follows the read so r_data stays put between reads
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                sel_q <= '0;
            end else if (r_en) begin
                sel_q <= r_addr[L-1:0];
            end
        end
        assign r_data = R_DATA_W'(ext_mem_r_data[sel_q*MINDATA_W +: MINDATA_W]);
    end

endmodule

// File: rtl/iob_fifo_sync_asym.sv
// Synchronous FIFO with independent write and read word widths.
// Occupancy is tracked in MINDATA_W units; full/empty come from level.
module iob_fifo_sync_asym
    import iob_fifo_sync_asym_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W = 10,
    localparam int MAXDATA_W = iob_max(W_DATA_W, R_DATA_W),
    localparam int MINDATA_W = iob_min(W_DATA_W, R_DATA_W),
    localparam int N = MAXDATA_W / MINDATA_W,
    localparam int MINADDR_W = ADDR_W - $clog2(N),
    localparam int WR = W_DATA_W / MINDATA_W,
    localparam int RR = R_DATA_W / MINDATA_W,
    localparam int W_ADDR_W = (W_DATA_W >= R_DATA_W) ? MINADDR_W : ADDR_W,
    localparam int R_ADDR_W = (R_DATA_W >= W_DATA_W) ? MINADDR_W : ADDR_W
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      rst,
    input  logic                      w_en,
    input  logic [W_DATA_W-1:0]       w_data,
    output logic                      w_full,
    input  logic                      r_en,
    output logic [R_DATA_W-1:0]       r_data,
    output logic                      r_valid,
    output logic                      r_empty,
    output logic [ADDR_W:0]           level,
    output logic [N-1:0]              ext_mem_w_en,
    output logic [N*MINADDR_W-1:0]    ext_mem_w_addr,
    output logic [N*MINDATA_W-1:0]    ext_mem_w_data,
    output logic                      ext_mem_r_en,
    output logic [N*MINADDR_W-1:0]    ext_mem_r_addr,
    input  logic [N*MINDATA_W-1:0]    ext_mem_r_data
);

    localparam logic [ADDR_W:0] WR_L = (ADDR_W+1)'(WR);
    localparam logic [ADDR_W:0] RR_L = (ADDR_W+1)'(RR);
    localparam logic [ADDR_W:0] FULL_TH = (ADDR_W+1)'((2**ADDR_W) - WR);

    logic [W_ADDR_W-1:0] w_ptr;
    logic [R_ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]     level_q;
    logic                w_acc;
    logic                r_acc;

    assign w_full  = level_q > FULL_TH;
    assign r_empty = level_q < RR_L;
    assign level   = level_q;

    // soft clear also blocks the RAM enables so contents stay untouched
    assign w_acc = w_en && !w_full && !rst;
    assign r_acc = r_en && !r_empty && !rst;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            level_q <= '0;
            r_valid <= 1'b0;
        end else if (rst) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            level_q <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_acc) w_ptr <= w_ptr + W_ADDR_W'(1);
            if (r_acc) r_ptr <= r_ptr + R_ADDR_W'(1);
            level_q <= level_q + (w_acc ? WR_L : '0) - (r_acc ? RR_L : '0);
            r_valid <= r_acc;
        end
    end

    iob_ram_2p_asym #(
        .W_DATA_W(W_DATA_W),
        .R_DATA_W(R_DATA_W),
        .ADDR_W  (ADDR_W),
        .N       (N)
    ) u_ram (
        .clk           (clk),
        .arst_n        (arst_n),
        .w_en          (w_acc),
        .w_addr        (w_ptr),
        .w_data        (w_data),
        .r_en          (r_acc),
        .r_addr        (r_ptr),
        .r_data        (r_data),
        .ext_mem_w_en  (ext_mem_w_en),
        .ext_mem_w_addr(ext_mem_w_addr),
        .ext_mem_w_data(ext_mem_w_data),
        .ext_mem_r_en  (ext_mem_r_en),
        .ext_mem_r_addr(ext_mem_r_addr),
        .ext_mem_r_data(ext_mem_r_data)
    );

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: 32->8 and 8->32 instances on bank models.
// Byte scoreboard for the wide-write instance, hand sequences for the other.
module tb_iob_fifo_sync_asym;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // instance A: W=32, R=8, ADDR_W=10 -> N=4, MINADDR_W=8
    logic        a_rst = 1'b0, a_w_en = 1'b0, a_r_en = 1'b0;
    logic [31:0] a_w_data = '0;
    logic        a_w_full, a_r_valid, a_r_empty;
    logic [7:0]  a_r_data;
    logic [10:0] a_level;
    logic [3:0]  a_mw_en;
    logic [31:0] a_mw_addr, a_mw_data, a_mr_addr;
    logic        a_mr_en;
    logic [31:0] a_mr_data = '0;
    logic [7:0]  mem_a [4][256];

    iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(10)) dut_a (
        .clk(clk), .arst_n(arst_n), .rst(a_rst),
        .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
        .r_en(a_r_en), .r_data(a_r_data), .r_valid(a_r_valid),
        .r_empty(a_r_empty), .level(a_level),
        .ext_mem_w_en(a_mw_en), .ext_mem_w_addr(a_mw_addr),
        .ext_mem_w_data(a_mw_data), .ext_mem_r_en(a_mr_en),
        .ext_mem_r_addr(a_mr_addr), .ext_mem_r_data(a_mr_data)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_mw_en[i]) mem_a[i][a_mw_addr[i*8 +: 8]] <= a_mw_data[i*8 +: 8];
            if (a_mr_en) a_mr_data[i*8 +: 8] <= mem_a[i][a_mr_addr[i*8 +: 8]];
        end
    end

    // instance B: W=8, R=32, ADDR_W=4 -> N=4, MINADDR_W=2
    logic        b_rst = 1'b0, b_w_en = 1'b0, b_r_en = 1'b0;
    logic [7:0]  b_w_data = '0;
    logic        b_w_full, b_r_valid, b_r_empty;
    logic [31:0] b_r_data;
    logic [4:0]  b_level;
    logic [3:0]  b_mw_en;
    logic [7:0]  b_mw_addr, b_mr_addr;
    logic [31:0] b_mw_data;
    logic        b_mr_en;
    logic [31:0] b_mr_data = '0;
    logic [7:0]  mem_b [4][4];

    iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
        .clk(clk), .arst_n(arst_n), .rst(b_rst),
        .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
        .r_en(b_r_en), .r_data(b_r_data), .r_valid(b_r_valid),
        .r_empty(b_r_empty), .level(b_level),
        .ext_mem_w_en(b_mw_en), .ext_mem_w_addr(b_mw_addr),
        .ext_mem_w_data(b_mw_data), .ext_mem_r_en(b_mr_en),
        .ext_mem_r_addr(b_mr_addr), .ext_mem_r_data(b_mr_data)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (b_mw_en[i]) mem_b[i][b_mw_addr[i*2 +: 2]] <= b_mw_data[i*8 +: 8];
            if (b_mr_en) b_mr_data[i*8 +: 8] <= mem_b[i][b_mr_addr[i*2 +: 2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model of instance A: byte queue, level, expected read bytes
    logic [7:0] byte_q [$];
    logic [7:0] exp_q [$];
    int lvl_a = 0;

    task automatic step_a(input logic w, input logic [31:0] d, input logic r);
        logic wa, ra;
        logic [7:0] e;
        a_w_en = w; a_w_data = d; a_r_en = r;
        wa = w && (lvl_a <= 1020);
        ra = r && (lvl_a >= 1);
        if (ra) exp_q.push_back(byte_q.pop_front());
        if (wa) for (int k = 0; k < 4; k++) byte_q.push_back(d[k*8 +: 8]);
        lvl_a = lvl_a + (wa ? 4 : 0) - (ra ? 1 : 0);
        #1;
        chk("a_mem_w_en", {28'd0, a_mw_en}, wa ? 32'hF : 32'h0);
        chk("a_mem_r_en", {31'd0, a_mr_en}, {31'd0, ra});
        @(posedge clk); #1;
        a_w_en = 1'b0; a_r_en = 1'b0;
        chk("a_r_valid", {31'd0, a_r_valid}, {31'd0, ra});
        if (ra) begin
            e = exp_q.pop_front();
            chk("a_r_data", {24'd0, a_r_data}, {24'd0, e});
        end
        chk("a_level", {21'd0, a_level}, lvl_a);
        chk("a_w_full", {31'd0, a_w_full}, (lvl_a > 1020) ? 32'd1 : 32'd0);
        chk("a_r_empty", {31'd0, a_r_empty}, (lvl_a < 1) ? 32'd1 : 32'd0);
    endtask

    task automatic step_b(input logic w, input logic [7:0] d, input logic r);
        b_w_en = w; b_w_data = d; b_r_en = r;
        @(posedge clk); #1;
        b_w_en = 1'b0; b_r_en = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] d;
        int          lvl;
        logic        full;
        logic        empty;
    } vec_t;
    vec_t vecs [$];

    function automatic void add_vec(input logic w, input logic r, input logic [31:0] d,
                                    input int lvl, input logic full, input logic empty);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.lvl = lvl; v.full = full; v.empty = empty;
        vecs.push_back(v);
    endfunction

    initial begin
        add_vec(1, 0, 32'h11223344, 4, 0, 0);
        add_vec(1, 0, 32'h55667788, 8, 0, 0);
        add_vec(1, 1, 32'h99AABBCC, 11, 0, 0);
        for (int i = 10; i >= 0; i--) add_vec(0, 1, 32'h0, i, 0, (i == 0));
        add_vec(1, 1, 32'hDEADBEEF, 4, 0, 0);
        for (int i = 3; i >= 0; i--) add_vec(0, 1, 32'h0, i, 0, (i == 0));

        #2;
        chk("rst_a_level", {21'd0, a_level}, 32'd0);
        chk("rst_a_full", {31'd0, a_w_full}, 32'd0);
        chk("rst_a_empty", {31'd0, a_r_empty}, 32'd1);
        chk("rst_a_valid", {31'd0, a_r_valid}, 32'd0);
        chk("rst_b_empty", {31'd0, b_r_empty}, 32'd1);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // swapped widths: four bytes make one read word
        step_b(1, 8'h0A, 0);
        step_b(1, 8'h0B, 0);
        step_b(1, 8'h0C, 0);
        chk("b_empty_3", {31'd0, b_r_empty}, 32'd1);
        chk("b_level_3", {27'd0, b_level}, 32'd3);
        step_b(1, 8'h0D, 0);
        chk("b_empty_4", {31'd0, b_r_empty}, 32'd0);
        step_b(0, 8'h00, 1);
        chk("b_valid", {31'd0, b_r_valid}, 32'd1);
        chk("b_data", b_r_data, 32'h0D0C0B0A);
        chk("b_level_0", {27'd0, b_level}, 32'd0);
        for (int i = 0; i < 16; i++) step_b(1, 8'(8'h20 + i), 0);
        chk("b_full", {31'd0, b_w_full}, 32'd1);
        chk("b_level_16", {27'd0, b_level}, 32'd16);
        step_b(0, 8'h00, 1);
        chk("b_data_wrap", b_r_data, 32'h23222120);

        // table-driven concurrent read/write sequence
        foreach (vecs[i]) begin
            step_a(vecs[i].w, vecs[i].d, vecs[i].r);
            chk("vec_level", {21'd0, a_level}, vecs[i].lvl);
            chk("vec_full", {31'd0, a_w_full}, {31'd0, vecs[i].full});
            chk("vec_empty", {31'd0, a_r_empty}, {31'd0, vecs[i].empty});
        end

        // fill to full, then one extra write
        for (int i = 0; i < 256; i++) step_a(1, 32'(i + 10), 0);
        chk("fill_full", {31'd0, a_w_full}, 32'd1);
        chk("fill_level", {21'd0, a_level}, 32'd1024);
        step_a(1, 32'hFFFFFFFF, 0);
        chk("fill_extra", {21'd0, a_level}, 32'd1024);

        // drain
        step_a(0, 32'h0, 1);
        chk("drain_first", {24'd0, a_r_data}, 32'h0A);
        for (int i = 1; i < 1024; i++) step_a(0, 32'h0, 1);
        chk("drain_empty", {31'd0, a_r_empty}, 32'd1);
        chk("drain_level", {21'd0, a_level}, 32'd0);
        step_a(0, 32'h0, 1);

        // wrap: write one word then read its four bytes
        for (int i = 0; i < 300; i++) begin
            step_a(1, $urandom, 0);
            for (int k = 0; k < 4; k++) step_a(0, 32'h0, 1);
        end

        // asynchronous reset mid-operation
        for (int i = 0; i < 26; i++) step_a(1, 32'(i * 3), 0);
        for (int i = 0; i < 4; i++) step_a(0, 32'h0, 1);
        chk("pre_arst_level", {21'd0, a_level}, 32'd100);
        arst_n = 1'b0;
        #1;
        chk("arst_level", {21'd0, a_level}, 32'd0);
        chk("arst_empty", {31'd0, a_r_empty}, 32'd1);
        chk("arst_valid", {31'd0, a_r_valid}, 32'd0);
        chk("arst_full", {31'd0, a_w_full}, 32'd0);
        byte_q.delete(); exp_q.delete(); lvl_a = 0;
        #1 arst_n = 1'b1;
        @(posedge clk); #1;

        // soft clear overrides a simultaneous write
        step_a(1, 32'hCAFEF00D, 0);
        a_rst = 1'b1; a_w_en = 1'b1; a_w_data = 32'h12345678;
        #1;
        chk("srst_mem_w_en", {28'd0, a_mw_en}, 32'h0);
        @(posedge clk); #1;
        a_rst = 1'b0; a_w_en = 1'b0;
        byte_q.delete(); lvl_a = 0;
        chk("srst_level", {21'd0, a_level}, 32'd0);
        chk("srst_empty", {31'd0, a_r_empty}, 32'd1);
        step_a(1, 32'hA1B2C3D4, 0);
        for (int k = 0; k < 4; k++) step_a(0, 32'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
